// File: rtl/sha256_wb_dma.sv
// Wishbone B3 read master feeding 512-bit blocks into a SHA-256 core.
// Define SHA256_WB_DMA_BURST_EN for incrementing-burst fetches.
module sha256_wb_dma #(
    parameter int NBLK_W = 16,
    parameter int ADR_W  = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic [ADR_W-1:0]  src_addr_i,
    input  logic [NBLK_W-1:0] nblocks_i,
    input  logic              use_iv_i,
    input  logic [255:0]      seed_state_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [255:0]      digest_o,
    output logic [ADR_W-1:0]  wbm_adr_o,
    input  logic [31:0]       wbm_dat_i,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_we_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              core_load_o,
    output logic [511:0]      core_data_o,
    output logic [255:0]      core_state_o,
    input  logic              core_busy_i,
    input  logic [255:0]      core_state_i
);

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [ADR_W-1:0] STEP = ADR_W'(4);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, WAIT_BUSY, WAIT_DONE, FINISH
    } state_t;

    state_t            state, state_n;
    logic [ADR_W-1:0]  addr;
    logic [NBLK_W-1:0] cnt;
    logic [3:0]        beat;
    logic [511:0]      data;
    logic [255:0]      chain, digest;
    logic              err, busy, done, cyc, cyc_n, load;
    logic              beat_ack, beat_err, last_beat, nb_zero, last_blk;

    assign beat_ack  = cyc & wbm_ack_i & ~wbm_err_i;
    assign beat_err  = cyc & wbm_err_i;
    assign last_beat = (beat == 4'hf);
    assign nb_zero   = (nblocks_i == '0);
    assign last_blk  = (cnt == NBLK_W'(1));

    always_comb begin
        state_n = state;
        cyc_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = nb_zero ? FINISH : FETCH;
                    cyc_n   = ~nb_zero;
                end
            end
            FETCH: begin
                if (beat_err) begin
                    state_n = FINISH;
                end else if (beat_ack) begin
`ifdef SHA256_WB_DMA_BURST_EN
                    cyc_n = ~last_beat;
`else
                    cyc_n = 1'b0;
`endif
                    if (last_beat) state_n = LOAD;
                end else begin
                    // also re-raises the strobe after a classic-cycle gap
                    cyc_n = 1'b1;
                end
            end
            LOAD:      state_n = WAIT_BUSY;
            WAIT_BUSY: if (core_busy_i) state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (!core_busy_i) begin
                    state_n = last_blk ? FINISH : FETCH;
                    cyc_n   = ~last_blk;
                end
            end
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            cyc   <= 1'b0;
            load  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            load  <= (state_n == LOAD) || (state_n == WAIT_BUSY);
            busy  <= (state_n != IDLE);
            done  <= (state_n == FINISH);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            addr   <= '0;
            cnt    <= '0;
            beat   <= '0;
            data   <= '0;
            chain  <= '0;
            digest <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        addr  <= {src_addr_i[ADR_W-1:2], 2'b00};
                        cnt   <= nblocks_i;
                        beat  <= '0;
                        err   <= 1'b0;
                        chain <= use_iv_i ? IV : seed_state_i;
                        if (nb_zero) digest <= use_iv_i ? IV : seed_state_i;
                    end
                end
                FETCH: begin
                    if (beat_err) begin
                        err <= 1'b1;
                    end else if (beat_ack) begin
                        data[{~beat, 5'h1f} -: 32] <= wbm_dat_i;
                        addr <= addr + STEP;
                        beat <= beat + 4'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!core_busy_i) begin
                        digest <= core_state_i;
                        chain  <= core_state_i;
                        cnt    <= cnt - NBLK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign err_o        = err;
    assign digest_o     = digest;
    assign wbm_adr_o    = addr;
    assign wbm_sel_o    = 4'hf;
    assign wbm_we_o     = 1'b0;
    assign wbm_bte_o    = 2'b00;
    assign wbm_cyc_o    = cyc;
    assign wbm_stb_o    = cyc;
    assign core_load_o  = load;
    assign core_data_o  = data;
    assign core_state_o = chain;
`ifdef SHA256_WB_DMA_BURST_EN
    assign wbm_cti_o = !cyc ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
`else
    assign wbm_cti_o = 3'b000;
`endif

endmodule

// File: tb/tb_sha256_wb_dma.sv
// Directed bench for sha256_wb_dma: memory slave plus behavioural SHA-256 core.
module tb_sha256_wb_dma;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  src_addr;
    logic [15:0]  nblocks;
    logic         use_iv;
    logic [255:0] seed;
    logic         busy, done, err;
    logic [255:0] digest;
    logic [31:0]  adr;
    logic [31:0]  dat;
    logic [3:0]   sel;
    logic         we;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic         cyc, stb, ack, berr;
    logic         core_load;
    logic [511:0] core_data;
    logic [255:0] core_state;
    logic         core_busy = 1'b0;
    logic [255:0] core_out = '0;

    logic [31:0]  mem [1024];
    int           stall_left = 0;
    int           ack_cnt = 0;
    int           ack_base = 0;
    int           err_off = -1;
    bit           stall_en = 0;
    int           busy_dly = 0;
    int           load_cnt = 0, hold_bad = 0;
    int           done_cnt = 0, cyc_cnt = 0;
    int           drop_bad = 0, berr_seen = 0;
    logic         berr_was = 1'b0;
    logic [31:0]  addr_log[$];
    logic [2:0]   cti_log[$];
    logic [255:0] st_log[$];
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    sha256_wb_dma dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
        .src_addr_i(src_addr), .nblocks_i(nblocks), .use_iv_i(use_iv),
        .seed_state_i(seed), .busy_o(busy), .done_o(done), .err_o(err),
        .digest_o(digest), .wbm_adr_o(adr), .wbm_dat_i(dat), .wbm_sel_o(sel),
        .wbm_we_o(we), .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_cyc_o(cyc),
        .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(berr),
        .core_load_o(core_load), .core_data_o(core_data),
        .core_state_o(core_state), .core_busy_i(core_busy),
        .core_state_i(core_out)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h,
                                                  input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // memory slave with programmable stalls and one injectable error beat
    assign dat  = mem[adr[11:2]];
    assign berr = cyc & stb & (stall_left == 0) & (ack_cnt - ack_base == err_off);
    assign ack  = cyc & stb & (stall_left == 0) & ~berr;

    always @(posedge clk) begin
        if (ack) begin
            addr_log.push_back(adr);
            cti_log.push_back(cti);
            ack_cnt    <= ack_cnt + 1;
            stall_left <= stall_en ? ((ack_cnt + 1) % 4) : 0;
        end else if (cyc && stb && stall_left > 0) begin
            stall_left <= stall_left - 1;
        end
    end

    always begin
        @(posedge clk); #1;
        if (rst_n && core_load && !core_busy) begin
            load_cnt++;
            st_log.push_back(core_state);
            core_out = sha_compress(core_state, core_data);
            repeat (busy_dly) begin @(posedge clk); #1; end
            if (!core_load) hold_bad++;
            core_busy = 1'b1;
            repeat (4) @(posedge clk);
            #1 core_busy = 1'b0;
        end
    end

    always @(negedge clk) berr_was = berr;

    always @(posedge clk) begin
        #1;
        if (done) done_cnt++;
        if (cyc) cyc_cnt++;
        if (berr_was) berr_seen++;
        if (berr_was && cyc) drop_bad++;
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_block(input int idx, input logic [511:0] blk);
        for (int k = 0; k < 16; k++) mem[idx*16 + k] = blk[511 - 32*k -: 32];
    endtask

    task automatic job_start(input logic [31:0] src, input logic [15:0] nb,
                             input logic iv, input logic [255:0] sd);
        @(posedge clk); #1;
        ack_base = ack_cnt;
        src_addr = src; nblocks = nb; use_iv = iv; seed = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget,
                             output int cycles, output logic err0);
        bit ok = 0;
        err0 = err;
        cycles = budget;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1; cycles = i; break; end
            @(posedge clk); #1;
        end
        check(tag, 256'(ok), 256'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_cond(input string tag, input int kind);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (kind == 0 && core_busy && !core_load) begin ok = 1; break; end
            if (kind == 1 && cyc && addr_log.size() - ack_base >= 5) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check(tag, 256'(ok), 256'(1));
    endtask

    int           cyc_n, d0, l0, c0, a0, s0, e0, bad;
    logic         err0;
    logic [255:0] b1_res;

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; nblocks = '0;
        use_iv = 1'b0; seed = '0;
        b1_res = sha_compress(IV, TWO_B1);
        #12;
        check("rst_ctrl", 256'({busy, done, err, cyc, stb, core_load}), 256'(0));
        check("rst_bus", 256'({adr, we, cti, bte}), 256'(0));
        check("rst_digest", digest, '0);
        check("rst_state", core_state, '0);
        rst_n = 1'b1;

        // single "abc" block from the IV
        load_block(0, ABC_BLK);
        d0 = done_cnt; l0 = load_cnt; a0 = addr_log.size();
        job_start(32'h1000, 16'd1, 1'b1, '0);
        wait_done("abc_done", 400, cyc_n, err0);
        check("abc_digest", digest, ABC_DIG);
        check("abc_err", 256'(err), 256'(0));
        check("abc_pulses", 256'(done_cnt - d0), 256'(1));
        check("abc_loads", 256'(load_cnt - l0), 256'(1));
        check("abc_adr0", 256'(addr_log[a0]), 256'(32'h1000));
        check("abc_adr15", 256'(addr_log[a0 + 15]), 256'(32'h103c));
        bad = 0;
        for (int k = 0; k < 16; k++) begin
`ifdef SHA256_WB_DMA_BURST_EN
            if (cti_log[a0 + k] != ((k == 15) ? 3'b111 : 3'b010)) bad++;
`else
            if (cti_log[a0 + k] != 3'b000) bad++;
`endif
        end
        check("abc_cti", 256'(bad), 256'(0));

        // two blocks, misaligned source, slave stalls and slow core busy
        load_block(0, TWO_B1);
        load_block(1, TWO_B2);
        stall_en = 1; busy_dly = 3;
        a0 = addr_log.size(); s0 = st_log.size(); l0 = load_cnt; h0_clear();
        job_start(32'h2003, 16'd2, 1'b1, '0);
        wait_done("two_done", 800, cyc_n, err0);
        check("two_digest", digest, TWO_DIG);
        check("two_adr0", 256'(addr_log[a0]), 256'(32'h2000));
        check("two_adr16", 256'(addr_log[a0 + 16]), 256'(32'h2040));
        check("two_chain", st_log[s0 + 1], b1_res);
        check("two_loads", 256'(load_cnt - l0), 256'(2));
        check("load_hold", 256'(hold_bad), 256'(0));
        stall_en = 0; busy_dly = 0;

        // zero blocks: immediate finish with the seed
        c0 = cyc_cnt; d0 = done_cnt;
        job_start(32'h1000, 16'd0, 1'b0, {32{8'h11}});
        wait_done("zero_done", 10, cyc_n, err0);
        check("zero_lat", 256'(cyc_n <= 1), 256'(1));
        check("zero_cyc", 256'(cyc_cnt - c0), 256'(0));
        check("zero_digest", digest, {32{8'h11}});
        check("zero_pulses", 256'(done_cnt - d0), 256'(1));

        // bus error on beat 7 of block 2
        err_off = 23; l0 = load_cnt; e0 = berr_seen;
        job_start(32'h2000, 16'd2, 1'b1, '0);
        wait_done("err_done", 800, cyc_n, err0);
        check("err_flag", 256'(err), 256'(1));
        check("err_seen", 256'(berr_seen - e0), 256'(1));
        check("err_cyc_drop", 256'(drop_bad), 256'(0));
        check("err_digest", digest, b1_res);
        check("err_loads", 256'(load_cnt - l0), 256'(1));
        err_off = -1;
        load_block(0, ABC_BLK);
        job_start(32'h1000, 16'd1, 1'b1, '0);
        wait_done("clr_done", 400, cyc_n, err0);
        check("err_cleared", 256'(err0), 256'(0));
        check("clr_digest", digest, ABC_DIG);

        // reset while the core is working
        job_start(32'h1000, 16'd1, 1'b1, '0);
        wait_cond("reach_wait_done", 0);
        #3 rst_n = 1'b0;
        #1;
        check("rstwd_ctrl", 256'({busy, done, err, cyc, stb, core_load}), 256'(0));
        check("rstwd_digest", digest, '0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a fetch
        job_start(32'h1000, 16'd1, 1'b1, '0);
        wait_cond("reach_fetch", 1);
        #3 rst_n = 1'b0;
        #1;
        check("rstf_ctrl", 256'({busy, cyc, stb, core_load}), 256'(0));
        check("rstf_adr", 256'(adr), 256'(0));
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        job_start(32'h1000, 16'd1, 1'b1, '0);
        wait_done("post_rst_done", 400, cyc_n, err0);
        check("post_rst_digest", digest, ABC_DIG);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic h0_clear();
        hold_bad = hold_bad;
    endtask

endmodule
